// File: rtl/cn_array.sv
// -----------------------------------------------------------------------------
// cn_array
// Array of WIDTH independent generalised Muller C-element lanes, each lane
// combining NIN inputs. Every input position can be inverted (NC-style) and
// can take part in both transitions (symmetric), only the rising transition
// (plus) or only the falling transition (minus). The lane output is a
// registered copy of the pre-capture value, captured when the lane is
// enabled. Each lane also reports a one-cycle toggle pulse and a stall flag
// when its inputs have disagreed for too many consecutive enabled cycles.
//
// Ports
//   CK         in   1           clock, rising edge
//   RSN        in   1           asynchronous active-low reset
//   ST         in   WIDTH       per-lane synchronous set (wins over ENA)
//   ENA        in   WIDTH       per-lane capture enable
//   CLR_STALL  in   1           synchronous clear of all stall counters
//   A          in   WIDTH*NIN   lane l input i at bit l*NIN+i
//   Q          out  WIDTH       registered C-element outputs
//   PRECAP     out  WIDTH       combinational next value per lane
//   TOGGLE     out  WIDTH       one-cycle pulse: Q changed at the previous edge
//   STALL      out  WIDTH       lane pending for >= STALL_LIMIT cycles
//   STALL_ANY  out  1           OR of STALL
// -----------------------------------------------------------------------------
module cn_array #(
   parameter int                WIDTH       = 4,
   parameter int                NIN         = 2,
   parameter logic [NIN-1:0]    INV_MASK    = {NIN{1'b0}},
   parameter logic [NIN-1:0]    PLUS_MASK   = {NIN{1'b0}},
   parameter logic [NIN-1:0]    MINUS_MASK  = {NIN{1'b0}},
   parameter logic [WIDTH-1:0]  RESET_VAL   = {WIDTH{1'b0}},
   parameter int                STALL_W     = 8,
   parameter int                STALL_LIMIT = 16
) (
   input  logic                   CK,
   input  logic                   RSN,
   input  logic [WIDTH-1:0]       ST,
   input  logic [WIDTH-1:0]       ENA,
   input  logic                   CLR_STALL,
   input  logic [WIDTH*NIN-1:0]   A,
   output logic [WIDTH-1:0]       Q,
   output logic [WIDTH-1:0]       PRECAP,
   output logic [WIDTH-1:0]       TOGGLE,
   output logic [WIDTH-1:0]       STALL,
   output logic                   STALL_ANY
);

   // Illegal configurations are rejected at elaboration time.
   if (NIN < 2 || NIN > 8) begin : g_err_nin
      $error("cn_array: NIN=%0d outside 2..8", NIN);
   end
   if ((PLUS_MASK & MINUS_MASK) != '0) begin : g_err_overlap
      $error("cn_array: an input cannot be both plus and minus");
   end
   // With at least one symmetric input, rise needs it at 1 and fall needs it
   // at 0, so rise and fall can never be true together.
   if ((PLUS_MASK | MINUS_MASK) == {NIN{1'b1}}) begin : g_err_nosym
      $error("cn_array: at least one symmetric input is required");
   end
   if (STALL_LIMIT < 1 || STALL_LIMIT > (2 ** STALL_W) - 1) begin : g_err_limit
      $error("cn_array: STALL_LIMIT=%0d outside 1..2^STALL_W-1", STALL_LIMIT);
   end

   localparam logic [STALL_W-1:0] CNT_MAX = {STALL_W{1'b1}};
   localparam logic [STALL_W-1:0] LIMIT   = STALL_W'(STALL_LIMIT);

   logic [WIDTH-1:0] q_q;
   logic [WIDTH-1:0] q_d;
   logic [WIDTH-1:0] tog_q;
   logic [WIDTH-1:0] tog_d;
   logic [WIDTH-1:0] rise;
   logic [WIDTH-1:0] fall;
   logic [WIDTH-1:0] pend;

   for (genvar l = 0; l < WIDTH; l++) begin : g_lane
      logic [NIN-1:0]     eff;
      logic [STALL_W-1:0] cnt_q;
      logic [STALL_W-1:0] cnt_d;

      assign eff = A[l*NIN +: NIN] ^ INV_MASK;

      // Minus-only inputs are ignored for the rising decision, plus-only
      // inputs are ignored for the falling decision.
      assign rise[l] = &(eff | MINUS_MASK);
      assign fall[l] = ~|(eff & ~PLUS_MASK);

      assign PRECAP[l] = rise[l] | (~fall[l] & q_q[l]);

      // Set has priority over capture; a disabled lane simply holds.
      assign q_d[l] = ST[l]  ? 1'b1      :
                      ENA[l] ? PRECAP[l] :
                               q_q[l];

      // Enabled, not being set, and the inputs neither all agree high nor low.
      assign pend[l] = ENA[l] & ~ST[l] & ~rise[l] & ~fall[l];

      always_comb begin
         cnt_d = '0;
         if (!CLR_STALL && pend[l]) begin
            cnt_d = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + STALL_W'(1);
         end
      end

      always_ff @(posedge CK or negedge RSN) begin
         if (!RSN) begin
            cnt_q <= '0;
         end else begin
            cnt_q <= cnt_d;
         end
      end

      assign STALL[l] = (cnt_q >= LIMIT);
   end

   // A change is flagged only for clocked updates; leaving reset is not an edge.
   assign tog_d = q_d ^ q_q;

   always_ff @(posedge CK or negedge RSN) begin
      if (!RSN) begin
         q_q   <= RESET_VAL;
         tog_q <= '0;
      end else begin
         q_q   <= q_d;
         tog_q <= tog_d;
      end
   end

   assign Q         = q_q;
   assign TOGGLE    = tog_q;
   assign STALL_ANY = |STALL;

endmodule

// File: tb/tb_cn_array.sv
module tb_cn_array;

   // Three configurations share clock and reset.
   //   d0: WIDTH=4 NIN=2, plain masks, STALL_W=8 STALL_LIMIT=4
   //   d1: WIDTH=2 NIN=3, PLUS=100 MINUS=010, RESET_VAL=10, STALL_W=3 LIMIT=5
   //   d2: WIDTH=4 NIN=2, INV=11, RESET_VAL=0101, STALL_W=3 LIMIT=7
   localparam int CW    [3] = '{4, 2, 4};
   localparam int CN    [3] = '{2, 3, 2};
   localparam int CINV  [3] = '{0, 0, 3};
   localparam int CPLUS [3] = '{0, 4, 0};
   localparam int CMINUS[3] = '{0, 2, 0};
   localparam int CRST  [3] = '{0, 2, 5};
   localparam int CSW   [3] = '{8, 3, 3};
   localparam int CLIM  [3] = '{4, 5, 7};

   logic CK = 1'b0;
   logic RSN;
   always #5 CK = ~CK;

   logic [31:0] a_v   [3];
   logic [31:0] st_v  [3];
   logic [31:0] ena_v [3];
   logic        clr_v [3];

   logic [3:0] q0, p0, t0, s0;  logic sa0;
   logic [1:0] q1, p1, t1, s1;  logic sa1;
   logic [3:0] q2, p2, t2, s2;  logic sa2;

   cn_array #(.WIDTH(4), .NIN(2), .STALL_W(8), .STALL_LIMIT(4)) u0 (
      .CK(CK), .RSN(RSN), .ST(st_v[0][3:0]), .ENA(ena_v[0][3:0]),
      .CLR_STALL(clr_v[0]), .A(a_v[0][7:0]),
      .Q(q0), .PRECAP(p0), .TOGGLE(t0), .STALL(s0), .STALL_ANY(sa0));

   cn_array #(.WIDTH(2), .NIN(3), .PLUS_MASK(3'b100), .MINUS_MASK(3'b010),
              .RESET_VAL(2'b10), .STALL_W(3), .STALL_LIMIT(5)) u1 (
      .CK(CK), .RSN(RSN), .ST(st_v[1][1:0]), .ENA(ena_v[1][1:0]),
      .CLR_STALL(clr_v[1]), .A(a_v[1][5:0]),
      .Q(q1), .PRECAP(p1), .TOGGLE(t1), .STALL(s1), .STALL_ANY(sa1));

   cn_array #(.WIDTH(4), .NIN(2), .INV_MASK(2'b11), .RESET_VAL(4'b0101),
              .STALL_W(3), .STALL_LIMIT(7)) u2 (
      .CK(CK), .RSN(RSN), .ST(st_v[2][3:0]), .ENA(ena_v[2][3:0]),
      .CLR_STALL(clr_v[2]), .A(a_v[2][7:0]),
      .Q(q2), .PRECAP(p2), .TOGGLE(t2), .STALL(s2), .STALL_ANY(sa2));

   logic [31:0] q_r [3], p_r [3], t_r [3], s_r [3];
   logic        sa_r[3];
   assign q_r[0] = {28'd0, q0};  assign p_r[0] = {28'd0, p0};
   assign t_r[0] = {28'd0, t0};  assign s_r[0] = {28'd0, s0};  assign sa_r[0] = sa0;
   assign q_r[1] = {30'd0, q1};  assign p_r[1] = {30'd0, p1};
   assign t_r[1] = {30'd0, t1};  assign s_r[1] = {30'd0, s1};  assign sa_r[1] = sa1;
   assign q_r[2] = {28'd0, q2};  assign p_r[2] = {28'd0, p2};
   assign t_r[2] = {28'd0, t2};  assign s_r[2] = {28'd0, s2};  assign sa_r[2] = sa2;

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // ---------------- reference model ----------------
   logic [31:0] m_q   [3];
   logic [31:0] m_tog [3];
   int          m_cnt [3][4];

   function automatic bit bitof(int v, int i);
      return bit'((v >> i) & 1);
   endfunction

   function automatic bit eff_in(int d, int l, int i);
      return a_v[d][l*CN[d]+i] ^ bitof(CINV[d], i);
   endfunction

   // Rising: every input not marked minus-only sits at 1.
   function automatic bit m_rise(int d, int l);
      for (int i = 0; i < CN[d]; i++)
         if (!bitof(CMINUS[d], i) && !eff_in(d, l, i)) return 1'b0;
      return 1'b1;
   endfunction

   // Falling: every input not marked plus-only sits at 0.
   function automatic bit m_fall(int d, int l);
      for (int i = 0; i < CN[d]; i++)
         if (!bitof(CPLUS[d], i) && eff_in(d, l, i)) return 1'b0;
      return 1'b1;
   endfunction

   function automatic bit m_pre(int d, int l);
      if (m_rise(d, l)) return 1'b1;
      if (m_fall(d, l)) return 1'b0;
      return m_q[d][l];
   endfunction

   task automatic model_reset();
      for (int d = 0; d < 3; d++) begin
         m_q[d]   = 32'(CRST[d]);
         m_tog[d] = '0;
         for (int l = 0; l < 4; l++) m_cnt[d][l] = 0;
      end
   endtask

   task automatic model_edge();
      for (int d = 0; d < 3; d++) begin
         logic [31:0] nq;
         nq = m_q[d];
         for (int l = 0; l < CW[d]; l++) begin
            bit pend;
            int cmax;
            cmax = (1 << CSW[d]) - 1;
            pend = ena_v[d][l] && !st_v[d][l] && !m_rise(d, l) && !m_fall(d, l);
            if (st_v[d][l])       nq[l] = 1'b1;
            else if (ena_v[d][l]) nq[l] = m_pre(d, l);
            if (clr_v[d] || !pend)       m_cnt[d][l] = 0;
            else if (m_cnt[d][l] < cmax) m_cnt[d][l] = m_cnt[d][l] + 1;
         end
         m_tog[d] = nq ^ m_q[d];
         m_q[d]   = nq;
      end
   endtask

   task automatic check_comb();
      for (int d = 0; d < 3; d++) begin
         logic [31:0] e;
         e = '0;
         for (int l = 0; l < CW[d]; l++) e[l] = m_pre(d, l);
         chk($sformatf("d%0d_precap", d), p_r[d], e);
      end
   endtask

   task automatic check_regs();
      for (int d = 0; d < 3; d++) begin
         logic [31:0] es;
         es = '0;
         for (int l = 0; l < CW[d]; l++) es[l] = (m_cnt[d][l] >= CLIM[d]);
         chk($sformatf("d%0d_q", d), q_r[d], m_q[d]);
         chk($sformatf("d%0d_toggle", d), t_r[d], m_tog[d]);
         chk($sformatf("d%0d_stall", d), s_r[d], es);
         chk($sformatf("d%0d_stall_any", d), 32'(sa_r[d]), 32'(|es));
      end
   endtask

   // Inputs are set at the falling edge; this checks PRECAP, clocks one edge
   // and checks the registered outputs at the next falling edge.
   task automatic step();
      #1 check_comb();
      @(posedge CK);
      model_edge();
      @(negedge CK);
      check_regs();
   endtask

   task automatic clear_inputs();
      for (int d = 0; d < 3; d++) begin
         a_v[d] = '0; st_v[d] = '0; ena_v[d] = '0; clr_v[d] = 1'b0;
      end
   endtask

   task automatic async_reset();
      #2 RSN = 1'b0;
      model_reset();
      #1 check_regs();
      check_comb();
      @(posedge CK);
      @(negedge CK);
      check_regs();
      RSN = 1'b1;
   endtask

   initial begin
      clear_inputs();
      RSN = 1'b1;
      #1 RSN = 1'b0;
      model_reset();
      @(negedge CK);
      check_regs();
      check_comb();
      @(negedge CK);
      check_regs();
      RSN = 1'b1;

      // d0 lane0: 11 captures 1, 01 holds, 00 falls.
      a_v[0] = 32'b00_00_00_11; ena_v[0] = 32'b0001;
      step();
      chk("tp_d0_q0_rise", 32'(q0[0]), 32'd1);
      chk("tp_d0_tog0_pulse", 32'(t0[0]), 32'd1);
      step();
      chk("tp_d0_tog0_clear", 32'(t0[0]), 32'd0);
      a_v[0] = 32'b01;
      step();
      chk("tp_d0_q0_hold", 32'(q0[0]), 32'd1);
      chk("tp_d0_pre0_hold", 32'(p0[0]), 32'd1);
      a_v[0] = 32'b00;
      step();
      chk("tp_d0_q0_fall", 32'(q0[0]), 32'd0);

      // d2 lane1 (inverted inputs): 00 sets, 11 clears.
      a_v[2] = 32'b00_00_00_00; ena_v[2] = 32'b0010;
      step();
      chk("tp_d2_nc_rise", 32'(q2[1]), 32'd1);
      a_v[2] = 32'b00_00_11_00;
      step();
      chk("tp_d2_nc_fall", 32'(q2[1]), 32'd0);

      // d1 lane0 with plus on bit2 and minus on bit1.
      ena_v[1] = 32'b01; a_v[1] = 32'b000_011;
      step();
      chk("tp_d1_hold0", 32'(q1[0]), 32'd0);
      a_v[1] = 32'b000_111;
      step();
      chk("tp_d1_rise", 32'(q1[0]), 32'd1);
      a_v[1] = 32'b000_100;
      step();
      chk("tp_d1_fall_plus_ignored", 32'(q1[0]), 32'd0);

      // d0 lane2 stall: disagreeing inputs held with ENA.
      clear_inputs();
      a_v[0] = 32'b00_10_00_00; ena_v[0] = 32'b0100;
      for (int k = 1; k <= 4; k++) begin
         step();
         chk($sformatf("tp_stall_edge%0d", k), 32'(s0[2]), 32'(k >= 4));
      end
      chk("tp_stall_any", 32'(sa0), 32'd1);
      clr_v[0] = 1'b1;
      step();
      chk("tp_stall_cleared", 32'(s0[2]), 32'd0);
      clr_v[0] = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         step();
         chk($sformatf("tp_restall_edge%0d", k), 32'(s0[2]), 32'(k >= 4));
      end

      // d2 lane0 saturation over 20 cycles (3-bit counter, limit 7).
      a_v[2] = 32'b00_00_00_01; ena_v[2] = 32'b0001;
      for (int k = 1; k <= 20; k++) step();
      chk("tp_sat_stall", 32'(s2[0]), 32'd1);

      // d0 lane3: set wins over a falling capture; ENA=0 with rise holds.
      clear_inputs();
      st_v[0] = 32'b1000; ena_v[0] = 32'b1000;
      step();
      chk("tp_set_wins", 32'(q0[3]), 32'd1);
      st_v[0] = '0; ena_v[0] = '0; a_v[0] = 32'b00_00_00_11;
      step();
      chk("tp_ena0_hold", 32'(q0[0]), 32'd0);

      // Mid-operation reset with Q=1111 and counters at 3.
      a_v[0] = 32'b11_11_11_11; ena_v[0] = 32'b1111;
      step();
      a_v[0] = 32'b10_10_10_10;
      for (int k = 0; k < 3; k++) step();
      chk("tp_pre_reset_q", 32'(q0), 32'hF);
      async_reset();
      chk("tp_reset_q", 32'(q0), 32'h0);

      // Randomized traffic; A is often held so stalls can build up.
      for (int c = 0; c < 400; c++) begin
         for (int d = 0; d < 3; d++) begin
            if ($urandom_range(0, 9) < 3) a_v[d] = $urandom;
            for (int l = 0; l < CW[d]; l++) begin
               ena_v[d][l] = ($urandom_range(0, 9) < 8);
               st_v[d][l]  = ($urandom_range(0, 19) == 0);
            end
            clr_v[d] = ($urandom_range(0, 29) == 0);
         end
         step();
         if (c == 200) async_reset();
      end

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=0 expected=1");
      $fatal(1, "timeout");
   end

endmodule
